// File: rtl/cordic_pkg.sv
// Shared word type, latency and float constants for the cosine streaming controller.
package cordic_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned COS_LATENCY = 4;

    typedef logic [DATA_W-1:0] float_t;

    localparam float_t FP_ZERO   = 32'h0000_0000;
    localparam float_t FP_ONE    = 32'h3F80_0000;
    localparam float_t FP_HALF   = 32'h3F00_0000;
    localparam float_t FP_PI_3   = 32'h3F86_0A92;
    localparam float_t FP_PI_2   = 32'h3FC9_0FDB;
    localparam float_t FP_PI     = 32'h4049_0FDB;
    localparam float_t FP_M_ONE  = 32'hBF80_0000;
    localparam float_t FP_M_HALF = 32'hBF00_0000;

endpackage

// File: rtl/cosine_stream_ctrl_if.sv
// Angle-in / result-out valid-ready stream bundle of the cosine controller.
interface cosine_stream_ctrl_if #(
    parameter int unsigned DATA_W = cordic_pkg::DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_angle;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;

    modport master (
        output in_valid, in_angle, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
        output in_ready, out_valid, out_result
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; storage is deliberately left unreset.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    input  logic                   rd_en_i,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              do_wr, do_rd;

    assign full_o    = (count_q == FullCnt);
    assign empty_o   = (count_q == '0);
    assign do_rd     = rd_en_i && !empty_o;
    // A write into a full FIFO is only taken when a pop frees the slot this edge.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_wr && !do_rd) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cosine_stream_ctrl.sv
// Credit-based streaming wrapper around a fixed-latency, non-stallable cosine pipeline.
module cosine_stream_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned DATA_W  = cordic_pkg::DATA_W,
    parameter int unsigned LATENCY = COS_LATENCY,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    cosine_stream_ctrl_if.slave    stream,
    output logic [DATA_W-1:0]      cos_angle,
    input  logic [DATA_W-1:0]      cos_result,
    output logic                   cos_clk_en,
    output logic                   cos_reset,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned OccW = $clog2(DEPTH) + 1;
    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam logic [OccW-1:0] DepthOcc = OccW'(DEPTH);
    localparam logic [CntW-1:0] RstLast  = CntW'(LATENCY - 1);

    logic               in_ready, accept, pop;
    logic               acc_q, acc_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]  angle_q, angle_d;
    logic [OccW-1:0]    occ_q, occ_d;
    logic [CntW-1:0]    rst_cnt_q, rst_cnt_d;
    logic               cos_rst_q, cos_rst_d;
    logic               fifo_wr, fifo_full, fifo_empty;
    logic [DATA_W-1:0]  fifo_rdata;
    logic [OccW-1:0]    fifo_count;

    // Credits cover in-flight angles plus queued results, so the FIFO can never overflow.
    assign in_ready = !cos_rst_q && (occ_q < DepthOcc);
    assign accept   = stream.in_valid && in_ready;
    assign pop      = !fifo_empty && stream.out_ready;
    assign fifo_wr  = vld_q[LATENCY-1];

    always_comb begin
        acc_d     = accept;
        vld_d     = (vld_q << 1) | LATENCY'(acc_q);
        angle_d   = accept ? stream.in_angle : angle_q;
        occ_d     = occ_q;
        rst_cnt_d = rst_cnt_q;
        cos_rst_d = cos_rst_q;
        if (accept && !pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (!accept && pop) begin
            occ_d = occ_q - OccW'(1);
        end
        if (cos_rst_q) begin
            rst_cnt_d = rst_cnt_q + CntW'(1);
            if (rst_cnt_q == RstLast) cos_rst_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= 1'b0;
            vld_q     <= '0;
            angle_q   <= '0;
            occ_q     <= '0;
            rst_cnt_q <= '0;
            cos_rst_q <= 1'b1;
        end else begin
            acc_q     <= acc_d;
            vld_q     <= vld_d;
            angle_q   <= angle_d;
            occ_q     <= occ_d;
            rst_cnt_q <= rst_cnt_d;
            cos_rst_q <= cos_rst_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_result_fifo (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wr_en_i   (fifo_wr),
        .wr_data_i (cos_result),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign stream.in_ready   = in_ready;
    assign stream.out_valid  = !fifo_empty;
    assign stream.out_result = fifo_empty ? '0 : fifo_rdata;
    assign cos_angle         = angle_q;
    assign cos_reset         = cos_rst_q;
    assign cos_clk_en        = reset;
    assign occupancy         = occ_q;

    no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(fifo_wr && fifo_full && !pop));
    credit_bound_a: assert property (@(posedge clk) disable iff (!reset)
        fifo_count <= occ_q);

endmodule

// File: tb/tb_cosine_stream_ctrl.sv
// Directed and randomized checks of cosine_stream_ctrl against a stand-in cosine pipeline.
module tb_cosine_stream_ctrl;
    import cordic_pkg::*;

    localparam int LAT   = COS_LATENCY;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] angle;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cos_angle, cos_result;
    logic        cos_clk_en, cos_reset;
    logic [3:0]  occupancy;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    bit          sb_en  = 1'b0;
    logic [31:0] sb_q[$];
    vec_t        vec[8];
    logic [31:0] pipe[LAT];

    cosine_stream_ctrl_if #(.DATA_W(32)) st ();

    cosine_stream_ctrl #(
        .DATA_W  (32),
        .LATENCY (LAT),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stream     (st),
        .cos_angle  (cos_angle),
        .cos_result (cos_result),
        .cos_clk_en (cos_clk_en),
        .cos_reset  (cos_reset),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Known angles map to their true cosine; anything else gets a distinct scramble.
    function automatic logic [31:0] cos_model(input logic [31:0] a);
        for (int i = 0; i < 8; i++) begin
            if (vec[i].angle == a) return vec[i].exp;
        end
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    always @(posedge clk) begin
        if (cos_reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (cos_clk_en) begin
            pipe[0] <= cos_model(cos_angle);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign cos_result = pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_fp(input string name, input logic [31:0] act, input logic [31:0] exp);
        logic [31:0] d;
        checks++;
        d = (act > exp) ? act - exp : exp - act;
        if ($isunknown(act) || act[31] !== exp[31] || d > 32'd4) begin
            errors++;
            $display("FAIL %s: got %h expected %h (+/-4 LSB)", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (sb_en && reset) begin
            if (st.out_valid && st.out_ready) begin
                pops++;
                if (sb_q.size() == 0) begin
                    check("sb_extra_pop", {31'd0, st.out_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_fp("sb_data", st.out_result, e);
                end
            end
            if (st.in_valid && st.in_ready) sb_q.push_back(cos_model(st.in_angle));
        end
    end

    // Entered at posedge+1 just after reset release, leaves at posedge+1.
    task automatic post_reset(input string tag);
        int low = 0;
        int ov  = 0;
        bit up  = 1'b0;
        for (int c = 0; c < LAT + 8; c++) begin
            @(negedge clk);
            if (!up && !st.in_ready) low++;
            else up = 1'b1;
            if (st.out_valid) ov++;
        end
        check({tag, "_rdy_low_cycles"}, low, LAT);
        check({tag, "_no_output"}, ov, 0);
        check({tag, "_occ"}, {28'd0, occupancy}, 0);
        check({tag, "_clk_en"}, {31'd0, cos_clk_en}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_in_reset(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, {31'd0, st.out_valid}, 0);
        check({tag, "_out_result"}, st.out_result, 0);
        check({tag, "_in_ready"}, {31'd0, st.in_ready}, 0);
        check({tag, "_occ"}, {28'd0, occupancy}, 0);
        check({tag, "_clk_en"}, {31'd0, cos_clk_en}, 0);
        check({tag, "_cos_reset"}, {31'd0, cos_reset}, 1);
        check({tag, "_cos_angle"}, cos_angle, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got, first, last, rdy_low, acc, sent;

        vec[0] = '{FP_ZERO,      FP_ONE};
        vec[1] = '{FP_PI_3,      FP_HALF};
        vec[2] = '{FP_PI_2,      32'hB33B_BD2E};
        vec[3] = '{FP_PI,        FP_M_ONE};
        vec[4] = '{32'h3F49_0FDB, 32'h3F35_04F3};
        vec[5] = '{FP_ONE,       32'h3F0A_5140};
        vec[6] = '{32'h4006_0A92, FP_M_HALF};
        vec[7] = '{32'h3F06_0A92, 32'h3F5D_B3D7};

        reset        = 1'b0;
        st.in_valid  = 1'b0;
        st.in_angle  = '0;
        st.out_ready = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("por");
        reset = 1'b1;
        post_reset("por");

        // Single accept of 0.0: latency and value
        st.in_valid = 1'b1;
        st.in_angle = FP_ZERO;
        @(posedge clk);
        #1;
        st.in_valid = 1'b0;
        n = 0;
        while (!st.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("single_latency", n, LAT + 1);
        check_fp("single_value", st.out_result, FP_ONE);
        check("single_occ", {28'd0, occupancy}, 1);
        repeat (2) @(posedge clk);
        #1;
        check_fp("single_hold", st.out_result, FP_ONE);
        st.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("single_popped", {31'd0, st.out_valid}, 0);
        check("empty_result_zero", st.out_result, 0);
        repeat (2) @(posedge clk);
        #1;
        check("empty_pop_occ", {28'd0, occupancy}, 0);
        check("empty_pop_valid", {31'd0, st.out_valid}, 0);

        // Table: eight back-to-back accepts with out_ready held high
        got = 0; first = -1; last = -1; rdy_low = 0;
        for (int c = 0; c < 30; c++) begin
            st.in_valid = (c < 8);
            st.in_angle = (c < 8) ? vec[c].angle : '0;
            @(negedge clk);
            if (c < 8 && !st.in_ready) rdy_low++;
            if (st.out_valid) begin
                if (got < 8) check_fp("b2b_result", st.out_result, vec[got].exp);
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk);
            #1;
        end
        st.in_valid = 1'b0;
        check("b2b_ready_low", rdy_low, 0);
        check("b2b_count", got, 8);
        check("b2b_first_cycle", first, LAT + 2);
        check("b2b_consecutive", last - first, 7);

        // Backpressure: fill credits, then pop and accept together
        sb_q.delete();
        pops  = 0;
        sb_en = 1'b1;
        st.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            st.in_valid = 1'b1;
            st.in_angle = vec[acc % 8].angle;
            @(negedge clk);
            if (st.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        st.in_valid = 1'b0;
        check("bp_accepts", acc, DEPTH);
        check("bp_ready", {31'd0, st.in_ready}, 0);
        check("bp_occ_full", {28'd0, occupancy}, DEPTH);
        st.out_ready = 1'b1;
        @(posedge clk);
        #1;
        st.out_ready = 1'b0;
        check("bp_credit_occ", {28'd0, occupancy}, DEPTH - 1);
        check("bp_credit_rdy", {31'd0, st.in_ready}, 1);
        st.in_valid  = 1'b1;
        st.in_angle  = vec[5].angle;
        st.out_ready = 1'b1;
        @(negedge clk);
        check("both_handshakes", {30'd0, st.in_ready, st.out_valid}, 32'd3);
        @(posedge clk);
        #1;
        st.in_valid  = 1'b0;
        st.out_ready = 1'b0;
        check("both_occ", {28'd0, occupancy}, DEPTH - 1);
        st.out_ready = 1'b1;
        for (int c = 0; c < 60 && occupancy != 0; c++) begin
            @(posedge clk);
            #1;
        end
        st.out_ready = 1'b0;
        check("bp_drain_occ", {28'd0, occupancy}, 0);
        check("bp_drain_sb", sb_q.size(), 0);
        check("bp_pops", pops, DEPTH + 1);

        // Reset with two queued results and three angles in flight
        sb_en = 1'b0;
        sb_q.delete();
        st.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st.in_angle = vec[i].angle;
            @(posedge clk);
            #1;
        end
        st.in_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("mid_queued_occ", {28'd0, occupancy}, 2);
        check("mid_queued_valid", {31'd0, st.out_valid}, 1);
        st.in_valid = 1'b1;
        for (int i = 2; i < 5; i++) begin
            st.in_angle = vec[i].angle;
            @(posedge clk);
            #1;
        end
        st.in_valid = 1'b0;
        check("mid_inflight_occ", {28'd0, occupancy}, 5);
        reset = 1'b0;
        check_in_reset("mid");
        reset = 1'b1;
        post_reset("mid");

        // Random valid/ready over 10k angles against the scoreboard
        sb_q.delete();
        pops  = 0;
        sent  = 0;
        sb_en = 1'b1;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            st.in_valid  = ($urandom_range(0, 9) < 7);
            st.in_angle  = $urandom();
            st.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (st.in_valid && st.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        st.in_valid  = 1'b0;
        st.out_ready = 1'b1;
        for (int c = 0; c < 200 && occupancy != 0; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rand_sent", sent, 10000);
        check("rand_pops", pops, 10000);
        check("rand_sb_empty", sb_q.size(), 0);
        check("rand_occ", {28'd0, occupancy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
